dcache_flush_seq: RTL and testbench

Sequences a full-cache flush of the data cache for fence, fence.i and debug entry, sized entirely from the derived cva6_cfg_t.
- Walks every (set, way) entry in the tag array.
- Writes back dirty lines through the miss-handler writeback port, then invalidates each valid entry.
- Sits between the controller flush request and the dcache tag/writeback arbiters; acknowledges completion with a single pulse.

---
 rtl/config_pkg.sv | 25 ++
 rtl/dcache_flush_pkg.sv | 26 ++
 rtl/dcache_flush_seq.sv | 146 ++++++++++++++
 tb/tb_dcache_flush_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Derived core configuration subset consumed by the data-cache flush sequencer.
package config_pkg;

    typedef struct packed {
        int unsigned DCACHE_NUM_WORDS;
        int unsigned DCACHE_SET_ASSOC;
        int unsigned DCACHE_SET_ASSOC_WIDTH;
        int unsigned DCACHE_TAG_WIDTH;
        int unsigned DCACHE_INDEX_WIDTH;
        int unsigned DCACHE_OFFSET_WIDTH;
        int unsigned PLEN;
    } cva6_cfg_t;

    // Small but consistent geometry so the sequencer elaborates standalone.
    localparam cva6_cfg_t cva6_cfg_empty = '{
        DCACHE_NUM_WORDS:       4,
        DCACHE_SET_ASSOC:       2,
        DCACHE_SET_ASSOC_WIDTH: 1,
        DCACHE_TAG_WIDTH:       10,
        DCACHE_INDEX_WIDTH:     6,
        DCACHE_OFFSET_WIDTH:    4,
        PLEN:                   16
    };

endpackage

// File: rtl/dcache_flush_pkg.sv
// Types and helpers shared by the data-cache flush sequencer.
package dcache_flush_pkg;

    import config_pkg::*;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WB,
        WB_WAIT,
        INV,
        DONE
    } flush_state_e;

    // Line address {tag, idx, offset zeros}; caller narrows to PLEN.
    function automatic logic [63:0] line_addr(
        input cva6_cfg_t   cfg,
        input logic [63:0] tag,
        input logic [63:0] idx
    );
        return (tag << cfg.DCACHE_INDEX_WIDTH)
             | (idx << cfg.DCACHE_OFFSET_WIDTH);
    endfunction

endpackage

// File: rtl/dcache_flush_seq.sv
// Full data-cache flush walker: reads every (set, way), writes back dirty
// lines, invalidates valid ones and pulses an ack when the walk is done.
module dcache_flush_seq
    import config_pkg::*;
    import dcache_flush_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty,
    localparam int unsigned IdxW =
        CVA6Cfg.DCACHE_INDEX_WIDTH - CVA6Cfg.DCACHE_OFFSET_WIDTH,
    localparam int unsigned WayW = CVA6Cfg.DCACHE_SET_ASSOC_WIDTH,
    localparam int unsigned TagW = CVA6Cfg.DCACHE_TAG_WIDTH,
    localparam int unsigned PlenW = CVA6Cfg.PLEN
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             inv_only_i,
    output logic             busy_o,
    output logic             flush_ack_o,
    output logic             tag_req_o,
    output logic             tag_we_o,
    input  logic             tag_gnt_i,
    output logic [IdxW-1:0]  tag_idx_o,
    output logic [WayW-1:0]  tag_way_o,
    input  logic             tag_valid_i,
    input  logic             tag_dirty_i,
    input  logic [TagW-1:0]  tag_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [PlenW-1:0] wb_addr_o,
    input  logic             wb_done_i,
    output logic             dirty_wb_o
);

    localparam logic [IdxW-1:0] LastIdx =
        IdxW'(CVA6Cfg.DCACHE_NUM_WORDS - 1);
    localparam logic [WayW-1:0] LastWay =
        WayW'(CVA6Cfg.DCACHE_SET_ASSOC - 1);

    flush_state_e    state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [WayW-1:0] way_q, way_d;
    logic [TagW-1:0] tag_q, tag_d;
    logic            inv_only_q, inv_only_d;

    logic            last_entry;
    logic [IdxW-1:0] nxt_idx;
    logic [WayW-1:0] nxt_way;

    // Way-minor walk; with one way LastWay is 0 so the way never moves.
    always_comb begin
        last_entry = (idx_q == LastIdx) && (way_q == LastWay);
        nxt_idx    = idx_q;
        nxt_way    = way_q + WayW'(1);
        if (way_q == LastWay) begin
            nxt_way = '0;
            nxt_idx = idx_q + IdxW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        way_d       = way_q;
        tag_d       = tag_q;
        inv_only_d  = inv_only_q;
        tag_req_o   = 1'b0;
        tag_we_o    = 1'b0;
        wb_valid_o  = 1'b0;
        dirty_wb_o  = 1'b0;
        flush_ack_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    inv_only_d = inv_only_i;
                    idx_d      = '0;
                    way_d      = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                tag_req_o = 1'b1;
                if (tag_gnt_i) state_d = CHECK;
            end
            CHECK: begin
                tag_d = tag_i;
                if (!tag_valid_i) begin
                    idx_d   = nxt_idx;
                    way_d   = nxt_way;
                    state_d = last_entry ? DONE : READ;
                end else if (tag_dirty_i && !inv_only_q) begin
                    state_d = WB;
                end else begin
                    state_d = INV;
                end
            end
            WB: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    dirty_wb_o = 1'b1;
                    state_d    = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (wb_done_i) state_d = INV;
            end
            INV: begin
                tag_req_o = 1'b1;
                tag_we_o  = 1'b1;
                if (tag_gnt_i) begin
                    idx_d   = nxt_idx;
                    way_d   = nxt_way;
                    state_d = last_entry ? DONE : READ;
                end
            end
            DONE: begin
                flush_ack_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o    = (state_q != IDLE);
    assign tag_idx_o = idx_q;
    assign tag_way_o = way_q;
    assign wb_addr_o = PlenW'(line_addr(CVA6Cfg, 64'(tag_q), 64'(idx_q)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            way_q      <= '0;
            tag_q      <= '0;
            inv_only_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            way_q      <= way_d;
            tag_q      <= tag_d;
            inv_only_q <= inv_only_d;
        end
    end

endmodule

// File: tb/tb_dcache_flush_seq.sv
// Scoreboard bench for dcache_flush_seq: tag/writeback responders plus a
// monitor popping expected tag, writeback and ack events in order.
module tb_dcache_flush_seq;

    import config_pkg::*;

    localparam int NW = 4;
    localparam int NA = 2;
    localparam int TW = 10;
    localparam int PW = 16;

    localparam cva6_cfg_t Cfg = '{
        DCACHE_NUM_WORDS:       NW,
        DCACHE_SET_ASSOC:       NA,
        DCACHE_SET_ASSOC_WIDTH: 1,
        DCACHE_TAG_WIDTH:       TW,
        DCACHE_INDEX_WIDTH:     6,
        DCACHE_OFFSET_WIDTH:    4,
        PLEN:                   PW
    };

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          inv_only_i = 1'b0;
    logic          busy_o, flush_ack_o;
    logic          tag_req_o, tag_we_o;
    logic          tag_gnt_i = 1'b0;
    logic [1:0]    tag_idx_o;
    logic [0:0]    tag_way_o;
    logic          tag_valid_i = 1'b0;
    logic          tag_dirty_i = 1'b0;
    logic [TW-1:0] tag_i = '0;
    logic          wb_valid_o;
    logic          wb_ready_i = 1'b0;
    logic [PW-1:0] wb_addr_o;
    logic          wb_done_i = 1'b0;
    logic          dirty_wb_o;

    dcache_flush_seq #(.CVA6Cfg(Cfg)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .inv_only_i  (inv_only_i),
        .busy_o      (busy_o),
        .flush_ack_o (flush_ack_o),
        .tag_req_o   (tag_req_o),
        .tag_we_o    (tag_we_o),
        .tag_gnt_i   (tag_gnt_i),
        .tag_idx_o   (tag_idx_o),
        .tag_way_o   (tag_way_o),
        .tag_valid_i (tag_valid_i),
        .tag_dirty_i (tag_dirty_i),
        .tag_i       (tag_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_addr_o   (wb_addr_o),
        .wb_done_i   (wb_done_i),
        .dirty_wb_o  (dirty_wb_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory seen by the responder and a shadow used to build expectations.
    logic          mv [NW][NA];
    logic          md [NW][NA];
    logic [TW-1:0] mt [NW][NA];
    logic          sv [NW][NA];
    logic          sd [NW][NA];
    logic [TW-1:0] st [NW][NA];

    logic [31:0] sbq [$];

    function automatic logic [31:0] ev(input int t, input int i, input int w);
        return {4'(t), 20'd0, 8'(i), 4'(w)};
    endfunction

    function automatic logic [31:0] ev_wb(input logic [PW-1:0] a);
        return {4'd3, 12'd0, a};
    endfunction

    localparam logic [31:0] EvAck = 32'h4000_0000;

    task automatic set_entry(input int i, input int w, input logic v,
                             input logic d, input logic [TW-1:0] t);
        mv[i][w] = v; md[i][w] = d; mt[i][w] = t;
        sv[i][w] = v; sd[i][w] = d; st[i][w] = t;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NW; i++)
            for (int w = 0; w < NA; w++)
                set_entry(i, w, 1'b0, 1'b0, '0);
    endtask

    task automatic push_flush(input logic inv);
        for (int i = 0; i < NW; i++) begin
            for (int w = 0; w < NA; w++) begin
                sbq.push_back(ev(1, i, w));
                if (sv[i][w]) begin
                    if (sd[i][w] && !inv)
                        sbq.push_back(ev_wb({st[i][w], 2'(i), 4'b0000}));
                    sbq.push_back(ev(2, i, w));
                end
                sv[i][w] = 1'b0;
                sd[i][w] = 1'b0;
            end
        end
        sbq.push_back(EvAck);
    endtask

    // Responders: tag array with grant delay, writeback with ready delay.
    int   gnt_dly = 0;
    int   wb_dly = 0;
    int   done_dly = 2;
    bit   stray_en = 0;
    int   gcnt = 0, wcnt = 0, dcnt = 0;
    bit   r_hs_t, r_rd_t, r_wr_t, r_req, r_wv, r_hs_w;
    int   r_i, r_w;

    always @(posedge clk_i) begin
        r_hs_t = tag_req_o && tag_gnt_i;
        r_rd_t = r_hs_t && !tag_we_o;
        r_wr_t = r_hs_t && tag_we_o;
        r_req  = tag_req_o;
        r_i    = int'(tag_idx_o);
        r_w    = int'(tag_way_o);
        r_wv   = wb_valid_o;
        r_hs_w = wb_valid_o && wb_ready_i;
        #1;
        if (!rst_ni) begin
            gcnt = 0; wcnt = 0; dcnt = 0;
            tag_gnt_i = 1'b0; wb_ready_i = 1'b0; wb_done_i = 1'b0;
        end else begin
            if (r_rd_t) begin
                tag_valid_i = mv[r_i][r_w];
                tag_dirty_i = md[r_i][r_w];
                tag_i       = mt[r_i][r_w];
            end else begin
                tag_valid_i = 1'($urandom);
                tag_dirty_i = 1'($urandom);
                tag_i       = TW'($urandom);
            end
            if (r_wr_t) begin
                mv[r_i][r_w] = 1'b0;
                md[r_i][r_w] = 1'b0;
            end
            gcnt = (!r_req || r_hs_t) ? 0 : gcnt + 1;
            tag_gnt_i = tag_req_o && (gcnt >= gnt_dly);
            wcnt = (!r_wv || r_hs_w) ? 0 : wcnt + 1;
            wb_ready_i = wb_valid_o && (wcnt >= wb_dly);
            wb_done_i = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) wb_done_i = 1'b1;
            end else if (stray_en && !r_hs_w
                         && $urandom_range(0, 3) == 0) begin
                wb_done_i = 1'b1;
            end
            if (r_hs_w) dcnt = done_dly;
        end
    end

    // Monitor
    int   ack_cnt = 0, ack_cyc = 0, wb_cnt = 0, dirty_cnt = 0;
    int   last_inv_cyc = 0, last_done_cyc = 0;
    logic [PW-1:0] last_wb_addr = '0;
    logic p_ack = 0, p_treq = 0, p_tgnt = 0, p_wv = 0, p_wr = 0;
    logic [4:0]    p_tsig = '0;
    logic [PW-1:0] p_addr = '0;

    task automatic sb_pop(input string tag, input logic [31:0] got);
        if (sbq.size() == 0) chk({tag, "_unexpected"}, got, 32'h0);
        else chk(tag, got, sbq.pop_front());
    endtask

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            p_ack = 0; p_treq = 0; p_wv = 0;
        end else begin
            if (tag_req_o && tag_gnt_i) begin
                sb_pop(tag_we_o ? "inv" : "rd",
                       ev(tag_we_o ? 2 : 1, int'(tag_idx_o),
                          int'(tag_way_o)));
                if (tag_we_o) last_inv_cyc = cyc;
            end
            if (wb_valid_o && wb_ready_i) begin
                sb_pop("wb", ev_wb(wb_addr_o));
                wb_cnt++;
                last_wb_addr = wb_addr_o;
            end
            if (dirty_wb_o || (wb_valid_o && wb_ready_i))
                chk("dirty_wb", 32'(dirty_wb_o),
                    32'(wb_valid_o && wb_ready_i));
            if (dirty_wb_o) dirty_cnt++;
            if (wb_done_i) last_done_cyc = cyc;
            if (flush_ack_o) begin
                chk("ack_pulse", 32'(p_ack), 32'h0);
                sb_pop("ack", EvAck);
                ack_cnt++;
                ack_cyc = cyc;
            end
            if (p_treq && !p_tgnt)
                chk("tag_hold", 32'({tag_req_o, tag_we_o, tag_idx_o,
                                     tag_way_o}), 32'(p_tsig));
            if (p_wv && !p_wr)
                chk("wb_hold", 32'({wb_valid_o, wb_addr_o}),
                    32'({1'b1, p_addr}));
            p_ack  = flush_ack_o;
            p_treq = tag_req_o;
            p_tgnt = tag_gnt_i;
            p_tsig = {tag_req_o, tag_we_o, tag_idx_o, tag_way_o};
            p_wv   = wb_valid_o;
            p_wr   = wb_ready_i;
            p_addr = wb_addr_o;
        end
    end

    function automatic logic [31:0] outs();
        return 32'({busy_o, flush_ack_o, tag_req_o, tag_we_o, wb_valid_o,
                    dirty_wb_o, tag_idx_o, tag_way_o, wb_addr_o});
    endfunction

    task automatic start_flush(input logic inv, output int t0);
        @(posedge clk_i); #2;
        flush_i = 1'b1;
        inv_only_i = inv;
        t0 = cyc;
        @(posedge clk_i); #2;
        flush_i = 1'b0;
        inv_only_i = 1'($urandom);
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int c0 = ack_cnt;
        int k = 0;
        while (ack_cnt == c0 && k < budget) begin
            @(negedge clk_i); #1;
            k++;
        end
        if (ack_cnt == c0) chk({tag, "_ack_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, a1, c0, d0, k;
        clear_all();
        repeat (3) @(negedge clk_i);
        chk("rst_outputs", outs(), 32'h0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("idle_outputs", outs(), 32'h0);

        // All invalid, grant immediate: ack at cycle 2N+1.
        push_flush(1'b0);
        start_flush(1'b0, t0);
        wait_ack("t1", 200);
        chk("t1_latency", 32'(ack_cyc - t0), 32'd17);
        chk("t1_no_wb", 32'(wb_cnt), 32'd0);
        chk("t1_sb_empty", 32'(sbq.size()), 32'd0);

        // Dirty (2,1) tag 0x1A: writeback then invalidate.
        set_entry(2, 1, 1'b1, 1'b1, 10'h1A);
        d0 = dirty_cnt;
        push_flush(1'b0);
        start_flush(1'b0, t0);
        wait_ack("t2", 200);
        chk("t2_wb_addr", 32'(last_wb_addr), 32'h06A0);
        chk("t2_dirty_cnt", 32'(dirty_cnt - d0), 32'd1);
        chk("t2_inv_after_done", 32'(last_inv_cyc > last_done_cyc), 32'd1);
        chk("t2_sb_empty", 32'(sbq.size()), 32'd0);

        // Same entry, invalidate only: one extra cycle.
        set_entry(2, 1, 1'b1, 1'b1, 10'h1A);
        c0 = wb_cnt;
        push_flush(1'b1);
        start_flush(1'b1, t0);
        wait_ack("t3", 200);
        chk("t3_latency", 32'(ack_cyc - t0), 32'd18);
        chk("t3_no_wb", 32'(wb_cnt - c0), 32'd0);
        chk("t3_sb_empty", 32'(sbq.size()), 32'd0);

        // Slow grant and ready, random contents, stray wb_done pulses.
        gnt_dly = 5; wb_dly = 3; stray_en = 1;
        for (int i = 0; i < NW; i++)
            for (int w = 0; w < NA; w++)
                set_entry(i, w, 1'($urandom), 1'($urandom), TW'($urandom));
        set_entry(0, 1, 1'b1, 1'b1, 10'h155);
        push_flush(1'b0);
        start_flush(1'b0, t0);
        wait_ack("t4", 2000);
        chk("t4_sb_empty", 32'(sbq.size()), 32'd0);
        gnt_dly = 0; wb_dly = 0;

        // Flush re-requested while busy and while in DONE is dropped.
        clear_all();
        c0 = ack_cnt;
        push_flush(1'b0);
        start_flush(1'b0, t0);
        repeat (3) @(posedge clk_i);
        #2 flush_i = 1'b1;
        @(posedge clk_i); #2 flush_i = 1'b0;
        wait_ack("t5", 200);
        flush_i = 1'b1;
        @(posedge clk_i); #2 flush_i = 1'b0;
        repeat (30) @(negedge clk_i);
        chk("t5_one_ack", 32'(ack_cnt - c0), 32'd1);
        chk("t5_idle", 32'(busy_o), 32'd0);
        chk("t5_sb_empty", 32'(sbq.size()), 32'd0);
        stray_en = 0;

        // flush_i held high: next flush starts right after IDLE.
        push_flush(1'b0);
        push_flush(1'b0);
        @(posedge clk_i); #2 flush_i = 1'b1;
        wait_ack("t6a", 200);
        a1 = ack_cyc;
        @(posedge clk_i); #2;
        @(posedge clk_i); #2 flush_i = 1'b0;
        chk("t6_restarted", 32'(busy_o), 32'd1);
        wait_ack("t6b", 200);
        chk("t6_gap", 32'(ack_cyc - a1), 32'd18);
        chk("t6_sb_empty", 32'(sbq.size()), 32'd0);

        // Reset during WB_WAIT aborts without an ack.
        set_entry(1, 0, 1'b1, 1'b1, 10'h2C3);
        done_dly = 50;
        push_flush(1'b0);
        c0 = wb_cnt;
        d0 = ack_cnt;
        start_flush(1'b0, t0);
        k = 0;
        while (wb_cnt == c0 && k < 200) begin
            @(negedge clk_i); #1;
            k++;
        end
        chk("t7_wb_seen", 32'(wb_cnt - c0), 32'd1);
        @(posedge clk_i); #2;
        chk("t7_busy_before", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("t7_async_outputs", outs(), 32'h0);
        repeat (3) @(negedge clk_i);
        sbq.delete();
        chk("t7_no_ack", 32'(ack_cnt - d0), 32'd0);
        rst_ni = 1'b1;
        done_dly = 2;
        clear_all();
        set_entry(1, 0, 1'b1, 1'b1, 10'h2C3);
        push_flush(1'b0);
        start_flush(1'b0, t0);
        wait_ack("t7", 300);
        chk("t7_sb_empty", 32'(sbq.size()), 32'd0);

        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
